// File: rtl/pq_pkg.sv
// Shared types for the priority-queue core and its downstream display stages.
package pq_pkg;

  // One seven-segment digit code: {3'b0,hex} for a value, all ones for blank.
  typedef logic [6:0] digit_t;

  localparam digit_t DIGIT_BLANK = 7'b1111111;

  // History display FSM: taking an entry, or pacing before the next one.
  typedef enum logic {HD_READY, HD_DWELL} hist_state_t;

endpackage

// File: rtl/pq_history_display_dwell_timer.sv
// Loadable down-counter that stops at zero; used to pace human-readable updates.
module dwell_timer #(
  parameter int unsigned DWELL = 100_000_000,
  localparam int TW = $clog2(DWELL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clr,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] count_reg;

  // clr wins over load; otherwise count down until zero and hold there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/pq_history_display.sv
// Takes entries removed from the priority queue, keeps the newest DEPTH of them
// as seven-segment digit codes, and paces acceptance with a dwell timer.
module pq_history_display
  import pq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int unsigned DWELL = 100_000_000,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pop_valid,
  input  logic [DATA_W-1:0]       pop_data,
  output logic                    pop_ready,
  input  logic                    clear,
  input  logic                    freeze,
  output digit_t [DEPTH-1:0]      dig,
  output logic [CNT_W-1:0]        total_cnt,
  output logic [2:0]              hist_cnt,
  output logic                    busy
);

  localparam int TW = $clog2(DWELL + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(DWELL - 1);
  localparam logic [2:0]    HIST_MAX   = 3'(DEPTH);

  hist_state_t          state_reg;
  logic                 ready_en_reg;
  digit_t [DEPTH-1:0]   hist_reg;
  digit_t [DEPTH-1:0]   hist_next;
  logic [CNT_W-1:0]     total_cnt_reg;
  logic [2:0]           hist_cnt_reg;
  logic                 accept;
  logic                 timer_zero;

  // ready_en_reg keeps pop_ready low on the reset cycle itself; clear blocks
  // a same-cycle accept so the core keeps holding that entry.
  assign pop_ready = (state_reg == HD_READY) && ready_en_reg && !freeze && !clear;
  assign accept    = pop_valid && pop_ready;
  assign busy      = (state_reg == HD_DWELL);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .clr      (clear),
    .load_val (TIMER_LOAD),
    .zero     (timer_zero)
  );

  // Shifted history: newest value enters slot 0, each slot takes its younger neighbour.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_shift
      if (gi == 0) begin : gen_head
        assign hist_next[gi] = digit_t'(pop_data);
      end else begin : gen_tail
        assign hist_next[gi] = hist_reg[gi-1];
      end
    end
  endgenerate

  // State machine: accept moves to DWELL, timer expiry returns to READY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= HD_READY;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (clear) begin
        state_reg <= HD_READY;
      end else begin
        case (state_reg)
          HD_READY: if (accept) state_reg <= HD_DWELL;
          HD_DWELL: if (timer_zero) state_reg <= HD_READY;
          default:  state_reg <= HD_READY;
        endcase
      end
    end
  end

  // History register: blank on reset/clear, shift on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_reg <= {DEPTH{DIGIT_BLANK}};
    end else if (clear) begin
      hist_reg <= {DEPTH{DIGIT_BLANK}};
    end else if (accept) begin
      hist_reg <= hist_next;
    end
  end

  // Counters: total wraps freely, history count saturates at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_cnt_reg <= '0;
      hist_cnt_reg  <= '0;
    end else if (clear) begin
      total_cnt_reg <= '0;
      hist_cnt_reg  <= '0;
    end else if (accept) begin
      total_cnt_reg <= total_cnt_reg + 1'b1;
      if (hist_cnt_reg != HIST_MAX) begin
        hist_cnt_reg <= hist_cnt_reg + 3'd1;
      end
    end
  end

  assign dig       = hist_reg;
  assign total_cnt = total_cnt_reg;
  assign hist_cnt  = hist_cnt_reg;

endmodule

// File: tb/tb_pq_history_display.sv
// Scoreboard bench for pq_history_display with DWELL=4, DEPTH=4, CNT_W=8.
module tb_pq_history_display;
  import pq_pkg::*;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int DWELL  = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              pop_valid = 1'b0;
  logic [DATA_W-1:0] pop_data = '0;
  logic              clear = 1'b0;
  logic              freeze = 1'b0;
  logic              pop_ready;
  digit_t [DEPTH-1:0] dig_w;
  logic [CNT_W-1:0]  total_cnt;
  logic [2:0]        hist_cnt;
  logic              busy;

  pq_history_display #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DWELL  (DWELL),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pop_valid (pop_valid),
    .pop_data  (pop_data),
    .pop_ready (pop_ready),
    .clear     (clear),
    .freeze    (freeze),
    .dig       (dig_w),
    .total_cnt (total_cnt),
    .hist_cnt  (hist_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    int         tot;
    int         hist;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   acc_n = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_blank(input string name);
    for (int i = 0; i < DEPTH; i++) chk(name, dig_w[i], DIGIT_BLANK);
  endtask

  // Issue one entry, push its expected result, wait (bounded) for the accept edge.
  task automatic push_entry(input logic [3:0] d, input int tot, input int hist, output int waited);
    exp_t e;
    int   start;
    e.data = d;
    e.tot  = tot;
    e.hist = hist;
    sb.push_back(e);
    start     = acc_n;
    pop_data  = d;
    pop_valid = 1'b1;
    waited    = 0;
    while (acc_n == start && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (acc_n == start) begin
      chk("accept_timeout", 0, 1);
      void'(sb.pop_back());
    end
  endtask

  // Monitor: every handshake pops one expectation and checks the result after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pop_valid && pop_ready) begin
        acc_n++;
        if (sb.size() == 0) begin
          chk("unexpected_accept", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("accept_data", pop_data, e.data);
          @(posedge clk);
          #2;
          chk("dig0", dig_w[0], {3'b000, e.data});
          chk("total_cnt", total_cnt, e.tot);
          chk("hist_cnt", hist_cnt, e.hist);
          $display("accept data=%0h dig0=%0h total=%0d hist=%0d", e.data, dig_w[0], total_cnt, hist_cnt);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int k;

    // Test 1: reset state, then first entry
    #2 rst = 1'b1;
    step(2);
    chk_blank("rst_dig");
    chk("rst_total", total_cnt, 0);
    chk("rst_hist", hist_cnt, 0);
    chk("rst_ready", pop_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    push_entry(4'h3, 1, 1, w);
    pop_valid = 1'b0;
    chk("t1_wait", w, 2);
    chk("t1_dig0", dig_w[0], 7'h03);
    for (int i = 1; i < DEPTH; i++) chk("t1_digN", dig_w[i], DIGIT_BLANK);
    chk("t1_busy", busy, 1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("t1_ready_window", pop_ready, (i == 5) ? 1 : 0);
    end
    step(1);

    // Test 2: clear, then five back-to-back entries
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk_blank("t2_clear_dig");
    chk("t2_clear_total", total_cnt, 0);
    for (int i = 1; i <= 5; i++) begin
      push_entry(4'(i), i, (i < 4) ? i : 4, w);
      chk("t2_spacing", w, (i == 1) ? 1 : 5);
    end
    pop_valid = 1'b0;
    chk("t2_dig0", dig_w[0], 7'h05);
    chk("t2_dig1", dig_w[1], 7'h04);
    chk("t2_dig2", dig_w[2], 7'h03);
    chk("t2_dig3", dig_w[3], 7'h02);
    chk("t2_hist", hist_cnt, 4);
    chk("t2_total", total_cnt, 5);

    // Test 3: clear in the same cycle as a valid entry
    k = 0;
    while (busy && k < 20) begin
      step(1);
      k++;
    end
    chk("t3_idle", busy, 0);
    pop_data  = 4'h7;
    pop_valid = 1'b1;
    clear     = 1'b1;
    #1;
    chk("t3_ready_blocked", pop_ready, 0);
    step(1);
    clear = 1'b0;
    chk_blank("t3_dig");
    chk("t3_total", total_cnt, 0);
    chk("t3_hist", hist_cnt, 0);
    push_entry(4'h7, 1, 1, w);
    chk("t3_next_accept", w, 1);

    // Test 4: freeze raised mid-dwell, held 10 cycles
    step(1);
    freeze   = 1'b1;
    pop_data = 4'h9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_ready_frozen", pop_ready, 0);
      chk("t4_dig0_frozen", dig_w[0], 7'h07);
      chk("t4_dig1_frozen", dig_w[1], DIGIT_BLANK);
      @(posedge clk);
      #1;
    end
    freeze = 1'b0;
    push_entry(4'h9, 2, 2, w);
    chk("t4_first_accept", w, 1);
    pop_valid = 1'b0;

    // Test 5: 256 accepts wrap the total counter
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    for (int i = 0; i < 256; i++) begin
      push_entry(4'(i % 16), (i + 1) % 256, (i + 1 < 4) ? i + 1 : 4, w);
    end
    pop_valid = 1'b0;
    chk("t5_total_wrap", total_cnt, 0);
    chk("t5_hist_sat", hist_cnt, 4);

    // Test 6: asynchronous reset mid-dwell
    push_entry(4'hA, 1, 4, w);
    pop_valid = 1'b0;
    step(2);
    rst = 1'b1;
    #1;
    chk_blank("t6_dig");
    chk("t6_total", total_cnt, 0);
    chk("t6_hist", hist_cnt, 0);
    chk("t6_ready", pop_ready, 0);
    chk("t6_busy", busy, 0);
    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready_release", pop_ready, 0);
    @(posedge clk);
    #1;
    chk("t6_ready_after", pop_ready, 1);
    chk("t6_busy_after", busy, 0);

    step(2);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
